// File: rtl/reg_dump_serializer.sv
// Snapshots the register bank's flattened debug vector on request and streams it
// out MS-byte-first per register over valid/ready. Optional trailing XOR byte: DUMP_CHECKSUM_EN.
module reg_dump_serializer #(
  parameter int SIZE          = 32,
  parameter int NUM_REGISTERS = 32,
  parameter int NUM_BYTES     = SIZE*NUM_REGISTERS/8,
  parameter int CNT_W         = $clog2(NUM_BYTES+1)
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          i_dump_req,
  input  logic [SIZE*NUM_REGISTERS-1:0] i_registers_debug,
  output logic [7:0]                    o_tx_data,
  output logic                          o_tx_valid,
  input  logic                          i_tx_ready,
  output logic                          o_busy,
  output logic                          o_done
);

  localparam int BPR   = SIZE/8;
  localparam int IDX_W = (NUM_BYTES > 1) ? $clog2(NUM_BYTES) : 1;

`ifdef DUMP_CHECKSUM_EN
  typedef enum logic [1:0] {IDLE, SEND, CSUM, DONE} state_t;
`else
  typedef enum logic [1:0] {IDLE, SEND, DONE} state_t;
`endif

  state_t                       state, state_n;
  logic [CNT_W-1:0]             cnt, cnt_n;
  logic [NUM_BYTES-1:0][7:0]    snap, snap_n;
  logic [NUM_BYTES-1:0][7:0]    in_bytes;
  logic [7:0]                   data_n;
  logic                         valid_n, busy_n, done_n;
  logic [IDX_W-1:0]             nxt_idx;
  logic                         last, xfer;
`ifdef DUMP_CHECKSUM_EN
  logic [7:0]                   csum, csum_n;
`endif

  // Reorder the bank vector into transmit order: byte j is register j/BPR, MS byte first.
  for (genvar j = 0; j < NUM_BYTES; j++) begin : g_byte
    assign in_bytes[j] = i_registers_debug[(j/BPR)*SIZE + (BPR-1-(j%BPR))*8 +: 8];
  end

  assign nxt_idx = IDX_W'(cnt + CNT_W'(1));
  assign last    = (cnt == CNT_W'(NUM_BYTES-1));
  assign xfer    = o_tx_valid && i_tx_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      cnt        <= '0;
      snap       <= '0;
      o_tx_data  <= '0;
      o_tx_valid <= 1'b0;
      o_busy     <= 1'b0;
      o_done     <= 1'b0;
`ifdef DUMP_CHECKSUM_EN
      csum       <= '0;
`endif
    end else begin
      state      <= state_n;
      cnt        <= cnt_n;
      snap       <= snap_n;
      o_tx_data  <= data_n;
      o_tx_valid <= valid_n;
      o_busy     <= busy_n;
      o_done     <= done_n;
`ifdef DUMP_CHECKSUM_EN
      csum       <= csum_n;
`endif
    end
  end

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    snap_n  = snap;
    data_n  = o_tx_data;
    valid_n = o_tx_valid;
    busy_n  = o_busy;
    done_n  = 1'b0;
`ifdef DUMP_CHECKSUM_EN
    csum_n  = csum;
`endif
    case (state)
      IDLE: begin
        cnt_n   = '0;
        valid_n = 1'b0;
        busy_n  = 1'b0;
        if (i_dump_req) begin
          snap_n  = in_bytes;
          data_n  = in_bytes[0];
          valid_n = 1'b1;
          busy_n  = 1'b1;
          state_n = SEND;
`ifdef DUMP_CHECKSUM_EN
          csum_n  = '0;
`endif
        end
      end
      SEND: begin
        if (xfer) begin
`ifdef DUMP_CHECKSUM_EN
          csum_n = csum ^ o_tx_data;
`endif
          if (last) begin
`ifdef DUMP_CHECKSUM_EN
            // Checksum must include the byte transferring right now.
            data_n  = csum ^ o_tx_data;
            state_n = CSUM;
`else
            valid_n = 1'b0;
            busy_n  = 1'b0;
            done_n  = 1'b1;
            state_n = DONE;
`endif
          end else begin
            cnt_n  = cnt + CNT_W'(1);
            data_n = snap[nxt_idx];
          end
        end
      end
`ifdef DUMP_CHECKSUM_EN
      CSUM: begin
        if (xfer) begin
          valid_n = 1'b0;
          busy_n  = 1'b0;
          done_n  = 1'b1;
          state_n = DONE;
        end
      end
`endif
      DONE: begin
        valid_n = 1'b0;
        busy_n  = 1'b0;
        state_n = IDLE;
      end
      default: begin
        valid_n = 1'b0;
        busy_n  = 1'b0;
        state_n = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_reg_dump_serializer.sv
// Directed bench for reg_dump_serializer: stream content, backpressure hold,
// snapshot freeze, ignored requests, async reset and (with DUMP_CHECKSUM_EN) the XOR byte.
module tb_reg_dump_serializer;

  localparam int SIZE = 32;
  localparam int NREG = 32;
  localparam int NB   = SIZE*NREG/8;
`ifdef DUMP_CHECKSUM_EN
  localparam int EXPN = NB+1;
`else
  localparam int EXPN = NB;
`endif

  logic                   clk = 1'b0;
  logic                   rst;
  logic                   i_dump_req;
  logic [SIZE*NREG-1:0]   i_registers_debug;
  logic [7:0]             o_tx_data;
  logic                   o_tx_valid;
  logic                   i_tx_ready;
  logic                   o_busy;
  logic                   o_done;

  reg_dump_serializer #(.SIZE(SIZE), .NUM_REGISTERS(NREG)) dut (
    .clk(clk), .rst(rst), .i_dump_req(i_dump_req),
    .i_registers_debug(i_registers_debug),
    .o_tx_data(o_tx_data), .o_tx_valid(o_tx_valid), .i_tx_ready(i_tx_ready),
    .o_busy(o_busy), .o_done(o_done)
  );

  always #5 clk = ~clk;

  int         checks = 0;
  int         errors = 0;
  logic [31:0] model [NREG];
  logic [7:0]  exp_b [NB+1];
  logic [7:0]  rx    [NB+2];
  int          rx_n, done_cnt, done_cyc;
  bit          aborted;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic load_model();
    logic [7:0] x;
    x = 8'h00;
    for (int r = 0; r < NREG; r++) i_registers_debug[r*SIZE +: SIZE] = model[r];
    for (int j = 0; j < NB; j++) begin
      exp_b[j] = 8'(model[j/4] >> (24 - 8*(j%4)));
      x ^= exp_b[j];
    end
    exp_b[NB] = x;
  endtask

  // Starts at a negedge; returns after o_done (+2 cycles), an abort, or the cycle bound.
  task automatic run_dump(input int rdy_pct, input int poke_at, input int abort_at);
    bit pv, pr, rdy, poked, req_clr;
    logic [7:0] pd;
    pv = 0; pr = 0; pd = '0; poked = 0; req_clr = 0;
    rx_n = 0; done_cnt = 0; done_cyc = -1; aborted = 0;
    i_dump_req = 1'b1;
    i_tx_ready = 1'b0;
    @(posedge clk);
    @(negedge clk);
    i_dump_req = 1'b0;
    for (int k = 1; k <= 3000; k++) begin
      if (req_clr) begin i_dump_req = 1'b0; req_clr = 0; end
      if (pv && !pr) begin
        chk("hold_valid", 32'(o_tx_valid), 32'd1);
        chk("hold_data", 32'(o_tx_data), 32'(pd));
      end
      if (o_tx_valid) chk("busy_with_valid", 32'(o_busy), 32'd1);
      if (o_done) begin
        done_cnt++;
        chk("busy_at_done", 32'(o_busy), 32'd0);
        if (done_cyc < 0) done_cyc = k;
      end
      if (abort_at >= 0 && rx_n == abort_at && o_tx_valid) begin
        #2 rst = 1'b1;
        #1;
        chk("abort_valid", 32'(o_tx_valid), 32'd0);
        chk("abort_busy", 32'(o_busy), 32'd0);
        chk("abort_done", 32'(o_done), 32'd0);
        chk("abort_data", 32'(o_tx_data), 32'd0);
        aborted = 1;
        return;
      end
      if (poke_at >= 0 && !poked && rx_n == poke_at) begin
        i_registers_debug = '1;
        i_dump_req = 1'b1;
        poked = 1; req_clr = 1;
      end
      rdy = ($urandom_range(0, 99) < rdy_pct);
      i_tx_ready = rdy;
      if (o_tx_valid && rdy) begin
        if (rx_n < NB+2) rx[rx_n] = o_tx_data;
        rx_n++;
      end
      pv = o_tx_valid; pr = rdy; pd = o_tx_data;
      if (done_cyc >= 0 && k >= done_cyc + 2) break;
      @(negedge clk);
    end
    i_dump_req = 1'b0;
    i_tx_ready = 1'b0;
    if (done_cyc < 0) chk("done_timeout", 32'd0, 32'd1);
  endtask

  task automatic check_stream(input bit timed);
    chk("byte_count", rx_n, EXPN);
    chk("done_pulses", done_cnt, 1);
    if (timed) chk("done_cycle", done_cyc, EXPN+1);
    for (int j = 0; j < EXPN && j < rx_n; j++) chk($sformatf("byte%0d", j), 32'(rx[j]), 32'(exp_b[j]));
  endtask

  task automatic idle_cycles(input int n);
    for (int k = 0; k < n; k++) begin
      i_tx_ready = 1'($urandom_range(0, 1));
      @(negedge clk);
      chk("idle_valid", 32'(o_tx_valid), 32'd0);
      chk("idle_busy", 32'(o_busy), 32'd0);
    end
  endtask

  initial begin
    rst = 1'b1;
    i_dump_req = 1'b0;
    i_tx_ready = 1'b0;
    i_registers_debug = '0;
    #3;
    chk("rst_data", 32'(o_tx_data), 32'd0);
    chk("rst_valid", 32'(o_tx_valid), 32'd0);
    chk("rst_busy", 32'(o_busy), 32'd0);
    chk("rst_done", 32'(o_done), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    idle_cycles(3);

    // Basic dump with ready held high
    for (int r = 0; r < NREG; r++) model[r] = 32'h0;
    model[1]  = 32'hDEADBEEF;
    model[31] = 32'h12345678;
    load_model();
    run_dump(100, -1, -1);
    check_stream(1);
    chk("b4", 32'(rx[4]), 32'hDE);
    chk("b5", 32'(rx[5]), 32'hAD);
    chk("b6", 32'(rx[6]), 32'hBE);
    chk("b7", 32'(rx[7]), 32'hEF);
    chk("b124", 32'(rx[124]), 32'h12);
    chk("b125", 32'(rx[125]), 32'h34);
    chk("b126", 32'(rx[126]), 32'h56);
    chk("b127", 32'(rx[127]), 32'h78);
`ifdef DUMP_CHECKSUM_EN
    chk("csum_basic", 32'(rx[NB]), 32'h2A);
`endif
    idle_cycles(2);

    // Backpressure at ~30% ready
    run_dump(30, -1, -1);
    check_stream(0);
    idle_cycles(2);

    // Snapshot freeze and ignored mid-dump request
    run_dump(100, 10, -1);
    check_stream(1);
    idle_cycles(3);

    // Async reset with random inputs mid-activity
    for (int r = 0; r < NREG; r++) i_registers_debug[r*SIZE +: SIZE] = $urandom;
    i_dump_req = 1'b1;
    @(negedge clk);
    i_dump_req = 1'b0;
    for (int k = 0; k < 3; k++) begin
      i_tx_ready = 1'($urandom_range(0, 1));
      @(negedge clk);
    end
    chk("pre_rst_valid", 32'(o_tx_valid), 32'd1);
    #2 rst = 1'b1;
    #1;
    chk("arst_valid", 32'(o_tx_valid), 32'd0);
    chk("arst_busy", 32'(o_busy), 32'd0);
    chk("arst_data", 32'(o_tx_data), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    idle_cycles(4);

    // Reset at byte 50, then a fresh full dump
    load_model();
    run_dump(100, -1, 50);
    chk("aborted", 32'(aborted), 32'd1);
    @(negedge clk);
    rst = 1'b0;
    idle_cycles(4);
    run_dump(100, -1, -1);
    check_stream(1);
    idle_cycles(2);

    // Single nonzero register
    for (int r = 0; r < NREG; r++) model[r] = 32'h0;
    model[1] = 32'hDEADBEEF;
    load_model();
    run_dump(100, -1, -1);
    check_stream(1);
`ifdef DUMP_CHECKSUM_EN
    chk("csum_reg1", 32'(rx[NB]), 32'h22);
`endif
    idle_cycles(2);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
